// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_driver_if : data/control bundle between a display client and the
// 7-segment scan driver.                                 Revision 1.0
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_lz;
  logic [DIGITS-1:0]   blink_mask;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp_in, load, blank_lz, blink_mask,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, blank_lz, blink_mask,
    output seg, dp, an, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_driver : time-multiplexed 7-segment driver with frame-boundary
// commit, leading-zero blanking and per-digit blink.      Revision 1.0
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(DIGITS - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);
  localparam logic                 c_act_low    = (ACTIVE_LOW != 0);
  localparam logic                 c_hex        = (HEX_MODE != 0);
  localparam logic [6:0]           c_seg_off    = c_act_low ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0]    c_an_off     = c_act_low ? '1 : '0;
  localparam logic [DIGITS-1:0]    c_an_one     = DIGITS'(1);

  logic [c_presc_w-1:0] r_presc;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_phase;
  logic [4*DIGITS-1:0]  r_pend_val;
  logic [DIGITS-1:0]    r_pend_dp;
  logic [4*DIGITS-1:0]  r_shad_val;
  logic [DIGITS-1:0]    r_shad_dp;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [DIGITS-1:0]    r_an;
  logic                 r_frame_done;

  logic                 w_tick;
  logic                 w_commit;
  logic [3:0]           w_code;
  logic                 w_zero_run;
  logic [DIGITS-1:0]    w_lz;
  logic                 w_blank;
  logic [6:0]           w_seg_al;
  logic                 w_dp_al;
  logic [DIGITS-1:0]    w_an_al;
  logic [6:0]           w_seg;
  logic                 w_dp;
  logic [DIGITS-1:0]    w_an;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    case (code)
      4'h0:    f_decode = 7'b1000000;
      4'h1:    f_decode = 7'b1111001;
      4'h2:    f_decode = 7'b0100100;
      4'h3:    f_decode = 7'b0110000;
      4'h4:    f_decode = 7'b0011001;
      4'h5:    f_decode = 7'b0010010;
      4'h6:    f_decode = 7'b0000010;
      4'h7:    f_decode = 7'b1111000;
      4'h8:    f_decode = 7'b0000000;
      4'h9:    f_decode = 7'b0010000;
      4'hA:    f_decode = c_hex ? 7'b0001000 : 7'h7F;
      4'hB:    f_decode = c_hex ? 7'b0000011 : 7'h7F;
      4'hC:    f_decode = c_hex ? 7'b1000110 : 7'h7F;
      4'hD:    f_decode = c_hex ? 7'b0100001 : 7'h7F;
      4'hE:    f_decode = c_hex ? 7'b0000110 : 7'h7F;
      default: f_decode = c_hex ? 7'b0001110 : 7'h7F;
    endcase
  endfunction

  assign w_tick   = (r_presc == c_presc_last);
  assign w_commit = w_tick && (r_idx == c_idx_last);

  always_comb begin
    w_code     = r_shad_val[{r_idx, 2'b00} +: 4];
    w_zero_run = 1'b1;
    w_lz       = '0;
    // Walk from the most significant digit; a digit is blanked while all above it are zero
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero_run = w_zero_run & (r_shad_val[4*i +: 4] == 4'h0);
      w_lz[i]    = bus.blank_lz & w_zero_run;
    end
    w_blank  = w_lz[r_idx] | (r_phase & bus.blink_mask[r_idx]);
    w_seg_al = w_blank ? 7'h7F : f_decode(w_code);
    w_dp_al  = w_blank | ~r_shad_dp[r_idx];
    w_an_al  = ~(c_an_one << r_idx);
    w_seg    = c_act_low ? w_seg_al : ~w_seg_al;
    w_dp     = c_act_low ? w_dp_al  : ~w_dp_al;
    w_an     = c_act_low ? w_an_al  : ~w_an_al;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_shad_val   <= '0;
      r_shad_dp    <= '0;
      r_seg        <= c_seg_off;
      r_dp         <= c_act_low;
      r_an         <= c_an_off;
      r_frame_done <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_presc_w'(1);
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
      end
      if (bus.load) begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
      end
      // A load in the commit cycle lands in pending only; shadow takes the older contents
      if (w_commit) begin
        r_shad_val <= r_pend_val;
        r_shad_dp  <= r_pend_dp;
        if (r_blink_cnt == c_blink_last) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
        end
      end
      r_frame_done <= w_commit;
      r_seg        <= w_seg;
      r_dp         <= w_dp;
      r_an         <= w_an;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed multi-digit 7-segment driver for the timer display. It holds a double-buffered BCD/hex value, decodes one digit per refresh slot, and drives shared segment lines plus one-hot digit enables. New display data is committed only at frame boundaries, so no digit tears. The block also supports leading-zero blanking and per-digit blinking, and replaces per-digit combinational decoders.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8.
CLK_DIV, 50000, clock cycles per digit slot; legal minimum 1, which gives a tick every cycle.
BLINK_FRAMES, 64, number of full frames per blink half-period; legal minimum 1.
HEX_MODE, 0, when 1 codes 10..15 render as A b C d E F; when 0 they render as blank.
ACTIVE_LOW, 1, when 1 seg, dp and an are active-low (board default); when 0 they are active-high.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*DIGITS  digit codes; nibble i is digit i; digit 0 is the rightmost (least significant)
dp_in  in  DIGITS  decimal point request per digit
load  in  1  one-cycle strobe that captures value and dp_in into the pending buffer
blank_lz  in  1  enables leading-zero blanking
blink_mask  in  DIGITS  digits to blink
seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp  out  1  decimal point segment
an  out  DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse on each frame commit

Behaviour:
- Reset (asynchronous, rst_n=0):
  - seg, dp and an all inactive (7'h7F, 1, all-ones when ACTIVE_LOW=1).
  - frame_done=0.
  - Prescaler, digit index, blink counter and blink phase all 0.
  - Pending and shadow buffers all 0.
  - Reset mid-frame aborts the frame; no partial state survives.
- Prescaler: counts 0..CLK_DIV-1. tick=1 in the cycle the count equals CLK_DIV-1, then the count wraps to 0.
- Digit index:
  - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - Otherwise it holds.
- Load:
  - load=1 captures value and dp_in into the pending buffer.
  - Multiple loads within a frame: the last one wins.
- Commit:
  - On tick with idx==DIGITS-1, shadow <= pending, and frame_done pulses in the same cycle the commit registers.
  - If load coincides with the commit cycle, the commit uses the pending contents from before that load. The new data appears one frame later.
- Outputs:
  - Registered. seg, dp and an reflect the idx and shadow of the previous cycle, a fixed 1-cycle latency.
  - Exactly one an bit is active at any time after the first post-reset clock.
- Decode (active-low form; invert all bits when ACTIVE_LOW=0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - HEX_MODE=0: codes 10..15 produce blank (all segments off); dp is still honoured.
- Leading-zero blanking:
  - When blank_lz=1, digit i is blanked if every shadow nibble from DIGITS-1 down to i is 0 and i≠0.
  - Digit 0 is never blanked by this rule.
  - Blanking turns off seg and dp.
- Blink:
  - The blink counter increments on each commit. When it reaches BLINK_FRAMES-1 it wraps and toggles the phase.
  - While phase=1, digits with blink_mask[i]=1 show seg and dp off.
  - blink_mask is sampled live (not buffered).
- an is still driven for a blanked digit, which keeps scan timing uniform.
- Simultaneous tick and reset: reset wins.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles → seg=7'h7F, an=4'hF, dp=1, frame_done=0. Release → an walks 1110, 1101, 1011, 0111 every CLK_DIV cycles (CLK_DIV=4 in bench) → digits show 0.
- Load 16'h1234 with dp_in=4'b0100, CLK_DIV=4 → the next frame after the commit shows 4 (0011001) on an=1110, 3 on 1101, 2 with dp=0 on 1011, 1 on 0111. frame_done pulses once per 16 cycles.
- Tearing: assert load with 16'h5678 while idx=2 → the current frame finishes with old digits and the new data starts at digit 0 of the next frame. Repeat with load exactly on the commit cycle → the data appears one frame later.
- Blanking and hex: HEX_MODE=0, value=16'h00A7, blank_lz=1 → digits 3 and 2 blank, digit 1 blank (code A), digit 0 shows 1111000. With HEX_MODE=1 → digit 1 shows 0001000. With value=0 and blank_lz=1 → only digit 0 shows 1000000.
- Blink: BLINK_FRAMES=2, blink_mask=4'b0001 → digit 0 is visible for 2 frames, then off for 2 frames; other digits stay unaffected.
- Edge: CLK_DIV=1 with DIGITS=1 → an is constantly active, a commit occurs every cycle, and frame_done is high every cycle. Assert rst_n mid-frame → outputs go inactive asynchronously.
